// File: rtl/inst_mem_responder.sv
// ---------------------------------------------------------------------------
// inst_mem_responder
//   Instruction memory on the fetch side of the RV64 core. A fetch (PC) that
//   is accepted gets its 32-bit instruction back exactly LATENCY cycles later.
//   The response carries the request address and an error flag. A flush
//   discards fetches still in flight, and a load port writes program words.
//
// Ports
//   Clk         in   clock, rising edge
//   Rst         in   asynchronous reset, active low
//   ReqValid    in   fetch request valid
//   PcIn        in   fetch byte address
//   ReqReady    out  request accepted this cycle when ReqValid is high
//   FlushIn     in   drop every fetch accepted before this edge
//   RspValid    out  one-cycle pulse per surviving accepted fetch
//   InstOut     out  fetched instruction (NOP when idle or on error)
//   RspAddr     out  address being answered (holds last value when idle)
//   RspErr      out  fetch was misaligned or outside the memory window
//   LoadEnable  in   program-load write strobe (blocks fetches that cycle)
//   LoadAddr    in   word index to write
//   LoadData    in   word to write
//   FetchCount  out  responses delivered, wraps at 2^32
// ---------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int                 ADDR_W     = 64,
  parameter int                 INST_W     = 32,
  parameter int                 DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int                 LATENCY    = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ReqValid,
  input  logic [ADDR_W-1:0]      PcIn,
  output logic                   ReqReady,
  input  logic                   FlushIn,
  output logic                   RspValid,
  output logic [INST_W-1:0]      InstOut,
  output logic [ADDR_W-1:0]      RspAddr,
  output logic                   RspErr,
  input  logic                   LoadEnable,
  input  logic [DEPTH_LOG2-1:0]  LoadAddr,
  input  logic [INST_W-1:0]      LoadData,
  output logic [31:0]            FetchCount
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("inst_mem_responder: LATENCY must be within 1..4");
  end

  localparam int               DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [INST_W-1:0] NOP  = INST_W'(32'h0000_0013);

  // Program storage; intentionally never reset.
  logic [INST_W-1:0] mem [DEPTH];

  // Pipeline stages: index 0 is the stage written at acceptance, index
  // LATENCY-1 drives the response outputs.
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] err_q,   err_d;
  logic [ADDR_W-1:0]  pc_q     [LATENCY];
  logic [ADDR_W-1:0]  pc_d     [LATENCY];
  logic [INST_W-1:0]  data_q   [LATENCY];

  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;

  logic                  accept;
  logic [ADDR_W-1:0]     offset;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  req_err;
  logic                  rsp_valid;
  logic                  rsp_err;

  // Load has priority over fetch, so a read never meets a write.
  assign ReqReady = Rst & ~LoadEnable;
  assign accept   = ReqValid & ReqReady;

  // A PC below BASE_ADDR wraps to a huge offset; it is caught by the
  // explicit compare, and anything past the last word shows up as set
  // bits above the word index.
  assign offset   = PcIn - BASE_ADDR;
  assign word_idx = offset[DEPTH_LOG2+1:2];
  assign req_err  = (PcIn[1:0] != 2'b00)
                  | (PcIn < BASE_ADDR)
                  | (|offset[ADDR_W-1:DEPTH_LOG2+2]);

  always_comb begin
    valid_d  = valid_q;
    err_d    = err_q;
    pc_d     = pc_q;

    // A request accepted together with a flush is the jump target: keep it.
    valid_d[0] = accept;
    if (accept) begin
      pc_d[0]  = PcIn;
      err_d[0] = req_err;
    end

    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1] & ~FlushIn;
      pc_d[k]    = pc_q[k-1];
      err_d[k]   = err_q[k-1];
    end
  end

  assign rsp_valid = valid_q[LATENCY-1];
  assign rsp_err   = err_q[LATENCY-1];

  always_comb begin
    last_addr_d = last_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    if (rsp_valid) begin
      last_addr_d = pc_q[LATENCY-1];
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q     <= '0;
      err_q       <= '0;
      last_addr_q <= '0;
      fetch_cnt_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pc_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      for (int k = 0; k < LATENCY; k++) begin
        pc_q[k] <= pc_d[k];
      end
    end
  end

  // Memory array and read-data pipeline; the data is only looked at while
  // its valid bit is set, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (LoadEnable) begin
      mem[LoadAddr] <= LoadData;
    end
    if (accept) begin
      data_q[0] <= mem[word_idx];
    end
    for (int k = 1; k < LATENCY; k++) begin
      data_q[k] <= data_q[k-1];
    end
  end

  assign RspValid   = rsp_valid;
  assign RspErr     = rsp_valid & rsp_err;
  assign InstOut    = (rsp_valid && !rsp_err) ? data_q[LATENCY-1] : NOP;
  assign RspAddr    = rsp_valid ? pc_q[LATENCY-1] : last_addr_q;
  assign FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 3) share one stimulus
// stream so each latency's timing can be checked against the same fetches.
module tb_inst_mem_responder;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqValid;
  logic [63:0] PcIn;
  logic        FlushIn;
  logic        LoadEnable;
  logic [11:0] LoadAddr;
  logic [31:0] LoadData;

  logic        rdy1, rv1, err1;
  logic [31:0] inst1, cnt1;
  logic [63:0] addr1;
  logic        rdy2, rv2, err2;
  logic [31:0] inst2, cnt2;
  logic [63:0] addr2;
  logic        rdy3, rv3, err3;
  logic [31:0] inst3, cnt3;
  logic [63:0] addr3;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 Clk = ~Clk;

  inst_mem_responder #(.LATENCY(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .PcIn(PcIn), .ReqReady(rdy1),
    .FlushIn(FlushIn), .RspValid(rv1), .InstOut(inst1), .RspAddr(addr1),
    .RspErr(err1), .LoadEnable(LoadEnable), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .FetchCount(cnt1));

  inst_mem_responder #(.LATENCY(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .PcIn(PcIn), .ReqReady(rdy2),
    .FlushIn(FlushIn), .RspValid(rv2), .InstOut(inst2), .RspAddr(addr2),
    .RspErr(err2), .LoadEnable(LoadEnable), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .FetchCount(cnt2));

  inst_mem_responder #(.LATENCY(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .PcIn(PcIn), .ReqReady(rdy3),
    .FlushIn(FlushIn), .RspValid(rv3), .InstOut(inst3), .RspAddr(addr3),
    .RspErr(err3), .LoadEnable(LoadEnable), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .FetchCount(cnt3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the negedge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic load_word(input logic [11:0] a, input logic [31:0] d);
    LoadEnable = 1'b1;
    LoadAddr   = a;
    LoadData   = d;
    tick();
    LoadEnable = 1'b0;
  endtask

  task automatic chk_rsp1(input string tag, input logic [63:0] a,
                          input logic [31:0] inst, input logic e);
    chk({tag, "_vld"},  {63'd0, rv1}, 64'd1);
    chk({tag, "_inst"}, {32'd0, inst1}, {32'd0, inst});
    chk({tag, "_addr"}, addr1, a);
    chk({tag, "_err"},  {63'd0, err1}, {63'd0, e});
  endtask

  initial begin
    Rst = 1'b0; ReqValid = 1'b0; PcIn = '0; FlushIn = 1'b0;
    LoadEnable = 1'b0; LoadAddr = '0; LoadData = '0;
    tick(2);

    // Reset state
    chk("rst_vld",  {63'd0, rv1}, 64'd0);
    chk("rst_inst", {32'd0, inst1}, {32'd0, NOP});
    chk("rst_addr", addr1, 64'd0);
    chk("rst_err",  {63'd0, err1}, 64'd0);
    chk("rst_cnt",  {32'd0, cnt1}, 64'd0);
    chk("rst_rdy",  {63'd0, rdy1}, 64'd0);
    Rst = 1'b1;
    #1;
    chk("rdy_after_rst", {63'd0, rdy3}, 64'd1);
    tick();

    load_word(12'h000, 32'h0010_0093);
    load_word(12'h001, 32'h0020_0113);
    load_word(12'hFFF, 32'hDEAD_BEEF);

    // Back-to-back fetches, LATENCY 1
    ReqValid = 1'b1; PcIn = 64'h8000_0000;
    tick();
    chk_rsp1("b2b0", 64'h8000_0000, 32'h0010_0093, 1'b0);
    PcIn = 64'h8000_0004;
    tick();
    chk_rsp1("b2b1", 64'h8000_0004, 32'h0020_0113, 1'b0);
    ReqValid = 1'b0;
    tick();
    chk("idle_vld",  {63'd0, rv1}, 64'd0);
    chk("idle_inst", {32'd0, inst1}, {32'd0, NOP});
    chk("idle_addr_hold", addr1, 64'h8000_0004);
    chk("idle_err",  {63'd0, err1}, 64'd0);
    chk("b2b_cnt",   {32'd0, cnt1}, 64'd2);

    // Error fetches, then the last in-range word
    ReqValid = 1'b1; PcIn = 64'h8000_0002;
    tick();
    chk_rsp1("misalign", 64'h8000_0002, NOP, 1'b1);
    PcIn = 64'h7FFF_FFFC;
    tick();
    chk_rsp1("below", 64'h7FFF_FFFC, NOP, 1'b1);
    PcIn = 64'h8000_4000;
    tick();
    chk_rsp1("past_end", 64'h8000_4000, NOP, 1'b1);
    PcIn = 64'h8000_3FFC;
    tick();
    chk_rsp1("last_word", 64'h8000_3FFC, 32'hDEAD_BEEF, 1'b0);
    ReqValid = 1'b0;
    tick(4);
    chk("err_cnt1", {32'd0, cnt1}, 64'd6);
    chk("err_cnt3", {32'd0, cnt3}, 64'd6);

    // Flush with LATENCY 3: only the request issued with the flush survives
    ReqValid = 1'b1; PcIn = 64'h8000_0000;
    tick();
    PcIn = 64'h8000_0004;
    tick();
    PcIn = 64'h8000_3FFC; FlushIn = 1'b1;
    tick();
    ReqValid = 1'b0; FlushIn = 1'b0;
    chk("flush_c3_vld", {63'd0, rv3}, 64'd0);
    tick();
    chk("flush_c4_vld", {63'd0, rv3}, 64'd0);
    tick();
    chk("flush_c5_vld",  {63'd0, rv3}, 64'd1);
    chk("flush_c5_inst", {32'd0, inst3}, 64'hDEAD_BEEF);
    chk("flush_c5_addr", addr3, 64'h8000_3FFC);
    tick();
    chk("flush_c6_vld", {63'd0, rv3}, 64'd0);
    chk("flush_cnt3",   {32'd0, cnt3}, 64'd7);
    chk("flush_cnt2",   {32'd0, cnt2}, 64'd8);
    chk("flush_cnt1",   {32'd0, cnt1}, 64'd9);

    // Load blocks fetch; refetch sees new data
    LoadEnable = 1'b1; LoadAddr = 12'h001; LoadData = 32'hCAFE_F00D;
    ReqValid = 1'b1; PcIn = 64'h8000_0004;
    #1;
    chk("load_rdy", {63'd0, rdy1}, 64'd0);
    tick();
    chk("load_no_rsp", {63'd0, rv1}, 64'd0);
    LoadEnable = 1'b0;
    tick();
    chk_rsp1("reload", 64'h8000_0004, 32'hCAFE_F00D, 1'b0);
    ReqValid = 1'b0;
    tick(4);
    chk("load_cnt1", {32'd0, cnt1}, 64'd10);

    // Reset with two fetches in flight (LATENCY 2)
    ReqValid = 1'b1; PcIn = 64'h8000_0000;
    tick();
    PcIn = 64'h8000_0004;
    tick();
    ReqValid = 1'b0; Rst = 1'b0;
    #1;
    chk("mrst_vld",  {63'd0, rv2}, 64'd0);
    chk("mrst_inst", {32'd0, inst2}, {32'd0, NOP});
    chk("mrst_addr", addr2, 64'd0);
    chk("mrst_cnt",  {32'd0, cnt2}, 64'd0);
    tick();
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_quiet", {63'd0, rv2}, 64'd0);
    end
    chk("mrst_cnt_after", {32'd0, cnt2}, 64'd0);
    ReqValid = 1'b1; PcIn = 64'h8000_0000;
    tick();
    ReqValid = 1'b0;
    tick();
    chk("mrst_mem_vld",  {63'd0, rv2}, 64'd1);
    chk("mrst_mem_inst", {32'd0, inst2}, 64'h0010_0093);
    tick(3);

    // Counter wrap
    force u_dut1.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut1.fetch_cnt_q;
    #1;
    chk("wrap_pre", {32'd0, cnt1}, 64'hFFFF_FFFF);
    ReqValid = 1'b1; PcIn = 64'h8000_0000;
    tick();
    ReqValid = 1'b0;
    chk("wrap_rsp", {63'd0, rv1}, 64'd1);
    tick();
    chk("wrap_post", {32'd0, cnt1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder serving the fetch side of the pipelined RV64 core.
- The core issues fetch addresses (PC); this block returns the 32-bit instruction a fixed LATENCY cycles later, tagged with its address and an error flag.
- It provides a flush for discarding in-flight fetches on jumps.
- It provides a program-load write port used by the bench/loader before and between runs.

Parameters:
- ADDR_W, 64, width of fetch address.
- INST_W, 32, instruction width.
- DEPTH_LOG2, 12, log2 of memory depth in words (4096 words).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
- LATENCY, 1, cycles from request acceptance to response; legal 1..4.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ReqValid  in  1  fetch request valid.
- PcIn  in  ADDR_W  fetch byte address.
- ReqReady  out  1  request can be accepted this cycle.
- FlushIn  in  1  discard all in-flight responses (jump taken).
- RspValid  out  1  response valid, one-cycle pulse per accepted request.
- InstOut  out  INST_W  fetched instruction.
- RspAddr  out  ADDR_W  address of the request being answered.
- RspErr  out  1  request was misaligned or out of range.
- LoadEnable  in  1  program-load write strobe.
- LoadAddr  in  DEPTH_LOG2  word index for load.
- LoadData  in  INST_W  word to write.
- FetchCount  out  32  count of responses delivered.

Behaviour:
- Reset (Rst=0, async): all pipeline valid bits cleared; RspValid=0, InstOut=32'h0000_0013 (NOP), RspAddr=0, RspErr=0, FetchCount=0, ReqReady=0. Memory contents are not reset.
- ReqReady = Rst & ~LoadEnable. Load has priority; no read is accepted in a load cycle, so read/write collision cannot occur.
- Accept = ReqValid & ReqReady. On accept, stage 1 captures valid=1, PcIn and err. Each cycle, stage k moves to stage k+1.
- The response drives outputs from stage LATENCY. The response for a request accepted at edge N is visible after edge N+LATENCY-1 (LATENCY=1: registered read, data visible the cycle after acceptance).
- One request may be accepted per cycle; back-to-back requests yield back-to-back responses, in order.
- Index = (PcIn - BASE_ADDR) >> 2, computed in ADDR_W bits.
- err = (PcIn[1:0] != 0) | (PcIn < BASE_ADDR) | (index >= 2^DEPTH_LOG2).
- When err=1: InstOut=32'h0000_0013, RspErr=1, RspAddr=PcIn, RspValid=1 (errors are still answered).
- When RspValid=0: InstOut holds NOP, RspErr=0, RspAddr holds its last value.
- FlushIn=1: clears the valid bits of all stages that hold requests accepted before this edge; those responses never appear.
  - A request accepted in the same cycle as FlushIn is kept (it is the jump target).
  - Flush with an empty pipeline has no effect.
- Load: at an edge with LoadEnable=1, mem[LoadAddr] <= LoadData. A fetch of that word accepted at any later edge returns the new data.
- FetchCount increments by 1 on every cycle RspValid=1 and wraps at 2^32. Flushed requests are not counted.
- Reset mid-operation: in-flight requests are dropped immediately; no response is emitted after reset release for requests accepted before reset.
- LATENCY outside 1..4 is an elaboration error.

Test Plan:
- Load mem[0]=32'h0010_0093 and mem[1]=32'h0020_0113. Fetch PcIn=0x8000_0000, then 0x8000_0004 back-to-back, LATENCY=1. Required: RspValid on two consecutive cycles, InstOut 0x0010_0093 then 0x0020_0113, RspAddr matching, RspErr=0, FetchCount=2.
- Fetch PcIn=0x8000_0002, then 0x7FFF_FFFC, then 0x8000_4000. Required: three responses, each with RspErr=1 and InstOut=0x0000_0013.
- LATENCY=3: issue requests at cycles 0, 1 and 2, assert FlushIn at cycle 2. Required: only the cycle-2 request responds, at cycle 5; FetchCount=1.
- Hold LoadEnable=1 with ReqValid=1. Required: ReqReady=0 and no response. Drop LoadEnable and refetch the loaded word. Required: returns the new data.
- Assert Rst low with two requests in flight (LATENCY=2), release after 1 cycle. Required: RspValid stays 0 and all outputs hold reset values; memory data survives a subsequent fetch.
- Preload FetchCount near wrap via 2^32 responses (or by forcing the counter). Required: 0xFFFF_FFFF rolls to 0 on the next response.
